loopyv_pipeline_ctrl: RTL and testbench

Central hazard and sequencing controller for the loopyV 5-stage pipeline (IF/DE/EX/MEM/WB).
- Generates the per-register enables and flushes for the IF/DE, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Produces the operand forwarding selects for operandA/operandB.
- Owns the data-memory request/grant/response handshake.
- Resolves load-use, branch-flush and memory-wait conflicts with a small FSM plus a pending-flush flag.

---
 rtl/loopyv_pipeline_ctrl_if.sv | 57 +++++
 rtl/loopyv_pipeline_ctrl.sv | 170 +++++++++++++++++
 tb/tb_loopyv_pipeline_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/loopyv_pipeline_ctrl_if.sv
// loopyv_pipeline_ctrl_if
//   Bundles the pipeline status, forwarding, control and data-memory
//   handshake signals that pass between the loopyV datapath and its
//   hazard/sequencing controller.
//   master : datapath side. Drives the stage status and dmem responses, and
//            receives the enables, flushes, forwarding selects and dmemReq.
//   slave  : controller side (loopyv_pipeline_ctrl).
//   REG_ADDR_W must match the REG_ADDR_W of the controller that uses it.
interface loopyv_pipeline_ctrl_if #(parameter int REG_ADDR_W = 5);
   // pipeline status
   logic [REG_ADDR_W-1:0] deRs1Addr;
   logic [REG_ADDR_W-1:0] deRs2Addr;
   logic                  deRs1Used;
   logic                  deRs2Used;
   logic [REG_ADDR_W-1:0] exRdAddr;
   logic                  exRdWriteEn;
   logic                  exIsLoad;
   logic                  exBranchTaken;
   logic [REG_ADDR_W-1:0] memRdAddr;
   logic                  memRdWriteEn;
   logic                  memValid;
   logic                  memIsLoad;
   logic [REG_ADDR_W-1:0] wbRdAddr;
   logic                  wbRdWriteEn;
   // data memory handshake
   logic                  dmemGnt;
   logic                  dmemRvalid;
   logic                  dmemReq;
   // pipeline control
   logic                  pcEn;
   logic                  ifdeEn;
   logic                  idexEn;
   logic                  exmemEn;
   logic                  memwbEn;
   logic                  ifdeFlush;
   logic                  idexFlush;
   logic [1:0]            fwdASel;
   logic [1:0]            fwdBSel;

   modport master (
      output deRs1Addr, deRs2Addr, deRs1Used, deRs2Used,
             exRdAddr, exRdWriteEn, exIsLoad, exBranchTaken,
             memRdAddr, memRdWriteEn, memValid, memIsLoad,
             wbRdAddr, wbRdWriteEn, dmemGnt, dmemRvalid,
      input  dmemReq, pcEn, ifdeEn, idexEn, exmemEn, memwbEn,
             ifdeFlush, idexFlush, fwdASel, fwdBSel
   );

   modport slave (
      input  deRs1Addr, deRs2Addr, deRs1Used, deRs2Used,
             exRdAddr, exRdWriteEn, exIsLoad, exBranchTaken,
             memRdAddr, memRdWriteEn, memValid, memIsLoad,
             wbRdAddr, wbRdWriteEn, dmemGnt, dmemRvalid,
      output dmemReq, pcEn, ifdeEn, idexEn, exmemEn, memwbEn,
             ifdeFlush, idexFlush, fwdASel, fwdBSel
   );
endinterface

// File: rtl/loopyv_pipeline_ctrl.sv
// loopyv_pipeline_ctrl
//   Hazard and sequencing controller for the loopyV 5-stage pipeline.
//   It produces the pipeline-register enables and flushes and the operand
//   forwarding selects, and it owns the data-memory request/grant/response
//   handshake. A 3-state FSM (RUN / WAIT_GNT / WAIT_DATA) freezes the
//   pipeline during memory waits. A branch that resolves during a freeze is
//   remembered in pendFlush and applied in the first unfrozen cycle.
//   All outputs are combinational from the state and the inputs.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   pif       : loopyv_pipeline_ctrl_if.slave (status in, control out)
//   stallCnt  : (LOOPYV_PERF_CNT_EN only) frozen + load-use cycles
//   flushCnt  : (LOOPYV_PERF_CNT_EN only) applied branch flushes
// Build option:
//   `define LOOPYV_PERF_CNT_EN to add the two 32-bit performance counters.
module loopyv_pipeline_ctrl #(
   parameter int REG_ADDR_W  = 5,
   parameter bit RESET_FLUSH = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   loopyv_pipeline_ctrl_if.slave pif
`ifdef LOOPYV_PERF_CNT_EN
   ,
   output logic [31:0]           stallCnt,
   output logic [31:0]           flushCnt
`endif
);

   localparam logic [1:0] RUN       = 2'd0;
   localparam logic [1:0] WAIT_GNT  = 2'd1;
   localparam logic [1:0] WAIT_DATA = 2'd2;

   logic [1:0] state;
   logic [1:0] nextState;
   logic       pendFlush;
   logic       frz;
   logic       reqRaw;
   logic       flushNow;
   logic       loadUse;

   // EX/MEM wins over MEM/WB; x0 is never forwarded.
   function automatic logic [1:0] fwdSel(
      input logic [REG_ADDR_W-1:0] rs,
      input logic                  used,
      input logic [REG_ADDR_W-1:0] memRd,
      input logic                  memWe,
      input logic [REG_ADDR_W-1:0] wbRd,
      input logic                  wbWe
   );
      if (used && memWe && (memRd != '0) && (memRd == rs))
         return 2'd1;
      else if (used && wbWe && (wbRd != '0) && (wbRd == rs))
         return 2'd2;
      else
         return 2'd0;
   endfunction

   // Freeze and next state. The cycles that release a wait (a store granted
   // in WAIT_GNT, rvalid in WAIT_DATA) are not frozen, so the whole
   // pipeline advances in that cycle and MEM/WB captures the load data.
   always_comb begin
      frz       = 1'b0;
      reqRaw    = 1'b0;
      nextState = state;
      case (state)
         RUN: begin
            reqRaw = pif.memValid;
            frz    = pif.memValid && (!pif.dmemGnt || pif.memIsLoad);
            if (pif.memValid) begin
               if (!pif.dmemGnt)
                  nextState = WAIT_GNT;
               else if (pif.memIsLoad)
                  nextState = WAIT_DATA;
            end
         end
         WAIT_GNT: begin
            reqRaw = pif.memValid;
            frz    = !(pif.dmemGnt && !pif.memIsLoad);
            if (pif.dmemGnt)
               nextState = pif.memIsLoad ? WAIT_DATA : RUN;
         end
         WAIT_DATA: begin
            // Request is withheld once granted; rvalid is only looked at
            // from the cycle after the grant.
            frz = !pif.dmemRvalid;
            if (pif.dmemRvalid)
               nextState = RUN;
         end
         default: nextState = RUN;
      endcase
   end

   assign flushNow = !frz && (pif.exBranchTaken || pendFlush);

   assign loadUse = pif.exIsLoad && pif.exRdWriteEn && (pif.exRdAddr != '0) &&
                    ((pif.deRs1Used && (pif.exRdAddr == pif.deRs1Addr)) ||
                     (pif.deRs2Used && (pif.exRdAddr == pif.deRs2Addr)));

   always_comb begin
      pif.pcEn      = 1'b1;
      pif.ifdeEn    = 1'b1;
      pif.idexEn    = 1'b1;
      pif.exmemEn   = 1'b1;
      pif.memwbEn   = 1'b1;
      pif.ifdeFlush = 1'b0;
      pif.idexFlush = 1'b0;
      pif.dmemReq   = reqRaw;
      pif.fwdASel   = fwdSel(pif.deRs1Addr, pif.deRs1Used, pif.memRdAddr,
                             pif.memRdWriteEn, pif.wbRdAddr, pif.wbRdWriteEn);
      pif.fwdBSel   = fwdSel(pif.deRs2Addr, pif.deRs2Used, pif.memRdAddr,
                             pif.memRdWriteEn, pif.wbRdAddr, pif.wbRdWriteEn);
      if (frz) begin
         pif.pcEn    = 1'b0;
         pif.ifdeEn  = 1'b0;
         pif.idexEn  = 1'b0;
         pif.exmemEn = 1'b0;
         pif.memwbEn = 1'b0;
      end else if (flushNow) begin
         // Flush outranks load-use: the dependent instruction is squashed.
         pif.ifdeFlush = 1'b1;
         pif.idexFlush = 1'b1;
      end else if (loadUse) begin
         // Hold PC and IF/DE, inject one bubble into ID/EX.
         pif.pcEn      = 1'b0;
         pif.ifdeEn    = 1'b0;
         pif.idexFlush = 1'b1;
      end
      if (rst) begin
         pif.pcEn      = 1'b0;
         pif.ifdeEn    = 1'b0;
         pif.idexEn    = 1'b0;
         pif.exmemEn   = 1'b0;
         pif.memwbEn   = 1'b0;
         pif.dmemReq   = 1'b0;
         pif.fwdASel   = 2'd0;
         pif.fwdBSel   = 2'd0;
         pif.ifdeFlush = RESET_FLUSH;
         pif.idexFlush = RESET_FLUSH;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= RUN;
         pendFlush <= 1'b0;
      end else begin
         state <= nextState;
         if (frz && pif.exBranchTaken)
            pendFlush <= 1'b1;
         else if (!frz)
            pendFlush <= 1'b0;
      end
   end

`ifdef LOOPYV_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stallCnt <= '0;
         flushCnt <= '0;
      end else begin
         if (frz || (!flushNow && loadUse))
            stallCnt <= stallCnt + 32'd1;
         if (flushNow)
            flushCnt <= flushCnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_loopyv_pipeline_ctrl.sv
// tb_loopyv_pipeline_ctrl
//   Directed test of loopyv_pipeline_ctrl. Inputs change 1 time unit after
//   the rising edge and outputs are checked 1 time unit after that.
module tb_loopyv_pipeline_ctrl;

   logic clk;
   logic rst;
   int   nChecks;
   int   nFails;

   loopyv_pipeline_ctrl_if #(.REG_ADDR_W(5)) pif ();

`ifdef LOOPYV_PERF_CNT_EN
   logic [31:0] stallCnt;
   logic [31:0] flushCnt;
   loopyv_pipeline_ctrl #(.REG_ADDR_W(5), .RESET_FLUSH(1'b1)) dut (
      .clk(clk), .rst(rst), .pif(pif.slave), .stallCnt(stallCnt), .flushCnt(flushCnt));
`else
   loopyv_pipeline_ctrl #(.REG_ADDR_W(5), .RESET_FLUSH(1'b1)) dut (
      .clk(clk), .rst(rst), .pif(pif.slave));
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // enables packed {pcEn,ifdeEn,idexEn,exmemEn,memwbEn}, flushes {ifde,idex}
   task automatic chkCtl(input string tag, input logic [4:0] en, input logic [1:0] fl,
                         input logic req);
      #1;
      chk({tag, ".en"}, {pif.pcEn, pif.ifdeEn, pif.idexEn, pif.exmemEn, pif.memwbEn}, en);
      chk({tag, ".flush"}, {pif.ifdeFlush, pif.idexFlush}, fl);
      chk({tag, ".req"}, pif.dmemReq, req);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      pif.deRs1Addr = '0; pif.deRs2Addr = '0; pif.deRs1Used = 0; pif.deRs2Used = 0;
      pif.exRdAddr = '0; pif.exRdWriteEn = 0; pif.exIsLoad = 0; pif.exBranchTaken = 0;
      pif.memRdAddr = '0; pif.memRdWriteEn = 0; pif.memValid = 0; pif.memIsLoad = 0;
      pif.wbRdAddr = '0; pif.wbRdWriteEn = 0; pif.dmemGnt = 0; pif.dmemRvalid = 0;
   endtask

   initial begin
      nChecks = 0;
      nFails  = 0;
      idle();
      rst = 1'b1;
      // forwarding inputs live during reset: selects must still be 0
      pif.memRdAddr = 5'd5; pif.memRdWriteEn = 1; pif.deRs1Addr = 5'd5; pif.deRs1Used = 1;
      pif.memValid = 1;
      chkCtl("reset", 5'b00000, 2'b11, 1'b0);
      chk("reset.fwdA", pif.fwdASel, 2'd0);
      step();
      rst = 1'b0;
      idle();
      chkCtl("run.idle", 5'b11111, 2'b00, 1'b0);

      // 1. forwarding
      pif.memRdAddr = 5'd5; pif.wbRdAddr = 5'd5; pif.memRdWriteEn = 1; pif.wbRdWriteEn = 1;
      pif.deRs1Addr = 5'd5; pif.deRs1Used = 1;
      #1 chk("fwd.exmem", pif.fwdASel, 2'd1);
      chk("fwd.Bunused", pif.fwdBSel, 2'd0);
      pif.deRs2Addr = 5'd5; pif.deRs2Used = 1;
      #1 chk("fwd.B.exmem", pif.fwdBSel, 2'd1);
      pif.memRdWriteEn = 0;
      #1 chk("fwd.memwb", pif.fwdASel, 2'd2);
      chk("fwd.B.memwb", pif.fwdBSel, 2'd2);
      pif.memRdAddr = '0; pif.wbRdAddr = '0; pif.deRs1Addr = '0; pif.deRs2Addr = '0;
      pif.memRdWriteEn = 1;
      #1 chk("fwd.x0", pif.fwdASel, 2'd0);
      chk("fwd.B.x0", pif.fwdBSel, 2'd0);
      step();
      idle();

      // 2. load-use: one bubble, then normal
      pif.exIsLoad = 1; pif.exRdWriteEn = 1; pif.exRdAddr = 5'd3;
      pif.deRs2Addr = 5'd3; pif.deRs2Used = 1;
      chkCtl("lu.stall", 5'b00111, 2'b01, 1'b0);
      step();
      pif.exIsLoad = 0; pif.exRdWriteEn = 0; pif.exRdAddr = '0;
      chkCtl("lu.bubble", 5'b11111, 2'b00, 1'b0);
      pif.exIsLoad = 1; pif.exRdWriteEn = 1;
      chkCtl("lu.x0", 5'b11111, 2'b00, 1'b0);
      step();
      idle();

      // 3. load, slow grant then slow data
      pif.memValid = 1; pif.memIsLoad = 1;
      chkCtl("ld.c0", 5'b00000, 2'b00, 1'b1);
      step();
      chkCtl("ld.c1", 5'b00000, 2'b00, 1'b1);
      chk("ld.stWaitGnt", dut.state, 2'd1);
      step();
      pif.dmemGnt = 1;
      chkCtl("ld.gnt", 5'b00000, 2'b00, 1'b1);
      step();
      pif.dmemGnt = 0;
      chkCtl("ld.c3", 5'b00000, 2'b00, 1'b0);
      step();
      chkCtl("ld.c4", 5'b00000, 2'b00, 1'b0);
      step();
      pif.dmemRvalid = 1;
      chkCtl("ld.rvalid", 5'b11111, 2'b00, 1'b0);
      step();
      idle();
      chkCtl("ld.after", 5'b11111, 2'b00, 1'b0);
      chk("ld.stRun", dut.state, 2'd0);

      // 4. store granted at once: no stall
      pif.memValid = 1; pif.memIsLoad = 0; pif.dmemGnt = 1;
      chkCtl("st.gnt", 5'b11111, 2'b00, 1'b1);
      step();
      chk("st.stRun", dut.state, 2'd0);
      idle();

      // 5. branch during WAIT_DATA, coincident load-use on release
      pif.memValid = 1; pif.memIsLoad = 1; pif.dmemGnt = 1;
      chkCtl("br.gnt", 5'b00000, 2'b00, 1'b1);
      step();
      pif.dmemGnt = 0; pif.exBranchTaken = 1;
      chkCtl("br.frz1", 5'b00000, 2'b00, 1'b0);
      step();
      pif.exBranchTaken = 0;
      chkCtl("br.frz2", 5'b00000, 2'b00, 1'b0);
      chk("br.pend", dut.pendFlush, 1'b1);
      step();
      pif.dmemRvalid = 1;
      pif.exIsLoad = 1; pif.exRdWriteEn = 1; pif.exRdAddr = 5'd7;
      pif.deRs1Addr = 5'd7; pif.deRs1Used = 1;
      chkCtl("br.apply", 5'b11111, 2'b11, 1'b0);
      step();
      idle();
      chkCtl("br.done", 5'b11111, 2'b00, 1'b0);
      chk("br.pendClr", dut.pendFlush, 1'b0);
      // unfrozen branch flushes immediately
      pif.exBranchTaken = 1;
      chkCtl("br.direct", 5'b11111, 2'b11, 1'b0);
      step();
      idle();

      // 6. async reset while in WAIT_GNT with a pending flush
      pif.memValid = 1; pif.memIsLoad = 1; pif.exBranchTaken = 1;
      step();
      pif.exBranchTaken = 0;
      chk("rst.preState", dut.state, 2'd1);
      #2 rst = 1'b1;
      chkCtl("rst.async", 5'b00000, 2'b11, 1'b0);
      chk("rst.state", dut.state, 2'd0);
      chk("rst.pend", dut.pendFlush, 1'b0);
      #1 rst = 1'b0;
      idle();
      chkCtl("rst.release", 5'b11111, 2'b00, 1'b0);
`ifdef LOOPYV_PERF_CNT_EN
      chk("cnt.stall0", stallCnt, 32'd0);
      chk("cnt.flush0", flushCnt, 32'd0);
      pif.exIsLoad = 1; pif.exRdWriteEn = 1; pif.exRdAddr = 5'd3;
      pif.deRs2Addr = 5'd3; pif.deRs2Used = 1;
      step();
      idle();
      pif.exBranchTaken = 1;
      step();
      idle();
      chk("cnt.stall1", stallCnt, 32'd1);
      chk("cnt.flush1", flushCnt, 32'd1);
`endif
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not finish, expected finish before 20000");
      $fatal(1);
   end

endmodule
